if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Reads a 32-bit RISC-V instruction as four byte-serial accesses from the shared byte-wide memory port. Assembles the bytes little-endian and presents {pc, inst} to decode through a one-entry output buffer.
- Honours the pipeline stall and redirects on a taken branch or jump from execute.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset.
- ADDR_W, 32: PC/address width.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-low reset.
- stall_in  input  1  decode cannot accept; the buffered instruction is held.
- jump_in  input  1  redirect request from execute.
- jump_addr_in  input  32  redirect target.
- mem_grant_in  input  1  memory controller accepts the byte request this cycle.
- mem_byte_in  input  8  read data for the request granted in the previous cycle.
- mem_req_out  output  1  byte read request.
- mem_addr_out  output  32  byte address of the request.
- pc_out  output  32  PC of the buffered instruction.
- inst_out  output  32  buffered instruction.
- inst_valid_out  output  1  pc_out/inst_out are valid.

Behaviour:
- Reset (rst_in=0 at an edge):
  - fetch_pc=RESET_PC.
  - issue_cnt=0, recv_cnt=0, asm=0.
  - Output buffer empty: inst_valid_out=0, pc_out=0, inst_out=0.
  - mem_req_out=0, mem_addr_out=0.
  - Reset mid-fetch discards everything; a byte returning on the cycle after reset is ignored.
  - The first request is raised in the first cycle with rst_in=1.
- Issue (combinational outputs):
  - mem_req_out=1 when issue_cnt<4 and the assembly slot is free, i.e. not holding a complete word.
  - mem_addr_out=fetch_pc+issue_cnt (32-bit wrap).
  - A request is issued at an edge where mem_req_out=1 and mem_grant_in=1; issue_cnt increments.
  - When mem_grant_in=0, the request stays asserted with the same address and nothing is counted.
- Receive:
  - Exactly one cycle after each issued request, mem_byte_in is written into asm byte recv_cnt and recv_cnt increments.
  - Byte k of the instruction = mem[fetch_pc+k]; inst[8k+7:8k]=byte k.
  - A one-bit "outstanding" flag tracks the in-flight request.
- Completion:
  - recv_cnt==4 means the word is complete.
  - If the output buffer is empty, or it is being accepted this edge, the word moves into the buffer: pc_out=fetch_pc, inst_out=asm, inst_valid_out=1.
  - On that move: fetch_pc+=4, issue_cnt=0, recv_cnt=0.
  - Otherwise the word waits in asm and issue is blocked.
  - The complete word may move in the same edge that its 4th byte arrives, so the buffer is loaded at that edge.
- Accept:
  - An edge with inst_valid_out=1 and stall_in=0 consumes the buffer.
  - inst_valid_out drops unless a new word loads at the same edge.
- Latency:
  - Continuous grant, empty buffer, no stall: requests in cycles t..t+3, bytes in t+1..t+4, inst_valid_out=1 in t+5.
  - Next requests begin t+5; steady state is one instruction per 5 cycles.
- Stall:
  - The buffer holds its values unchanged.
  - Prefetch of the next word continues until asm is complete, then waits.
- Jump (jump_in=1 at an edge) has priority over stall, accept and completion:
  - fetch_pc=jump_addr_in; issue_cnt=0, recv_cnt=0.
  - Buffer invalidated: inst_valid_out=0.
  - A byte returning in the next cycle for a request issued before or at the jump edge is discarded.
  - New requests start in the next cycle.
- Simultaneous jump and reset: reset wins.
- Misaligned jump_addr_in is fetched as given; there is no alignment exception.
- Output registers hold their values whenever no update occurs; pc_out/inst_out keep stale data while inst_valid_out=0.

Test Plan:
- Reset, mem[0..3]=13 05 A0 00, grant always 1 → requests at addresses 0,1,2,3 in cycles 1–4; inst_valid_out=1, inst_out=32'h00A00513, pc_out=0 in cycle 6 (first post-reset cycle = 1).
- Grant low in cycle 2 only → address 1 held for two cycles, no duplicate byte; valid one cycle later, same inst_out.
- stall_in=1 for 10 cycles after the first instruction → pc_out=0/inst_out held; word at pc=4 assembled, mem_req_out=0 until release; after stall drops, pc_out=4 valid in the next cycle.
- jump_in=1, jump_addr_in=32'h100 while byte 2 of pc=4 is in flight → that byte ignored, inst_valid_out=0, next requests 0x100..0x103, result pc_out=32'h100.
- rst_in=0 during byte 3 of a fetch → all outputs zero; fetch restarts at RESET_PC with correct bytes.
- fetch_pc=32'hFFFF_FFFE → addresses FFFF_FFFE, FFFF_FFFF, 0, 1; next fetch_pc=32'h0000_0002.

Source files
------------

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage feeding decode.
//
// A 32-bit instruction is read as four byte requests on the shared byte-wide
// memory port. The bytes are assembled little-endian. The finished word is
// handed to decode through a one-entry output buffer as {pc, inst}.
//
// Ports
//   clk_in          rising-edge clock
//   rst_in          synchronous, active-low reset
//   stall_in        decode cannot accept; buffered instruction is held
//   jump_in         redirect from execute (beats stall/accept/completion)
//   jump_addr_in    redirect target (fetched as given, no alignment check)
//   mem_grant_in    memory accepts the byte request this cycle
//   mem_byte_in     read data for the request granted in the previous cycle
//   mem_req_out     byte read request
//   mem_addr_out    byte address of the request
//   pc_out          PC of the buffered instruction
//   inst_out        buffered instruction
//   inst_valid_out  pc_out/inst_out are valid
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              stall_in,
  input  logic              jump_in,
  input  logic [ADDR_W-1:0] jump_addr_in,
  input  logic              mem_grant_in,
  input  logic [7:0]        mem_byte_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       inst_out,
  output logic              inst_valid_out
);

  // Output buffer entry handed to decode.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
  } fetch_ent_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_fetch_pc;     // address of byte 0 of the word in flight
  logic [2:0]        r_issue_cnt;    // bytes requested and granted (0..4)
  logic [2:0]        r_recv_cnt;     // bytes written into r_asm (0..4)
  logic [31:0]       r_asm;          // assembly slot
  logic              r_outstanding;  // a granted request returns data this cycle
  fetch_ent_t        r_buf;
  logic              r_valid;

  // ---------------------------------------------------------------------------
  // Combinational
  // ---------------------------------------------------------------------------
  logic              w_word_full;
  logic              w_word_done;
  logic              w_req;
  logic              w_issue;
  logic              w_accept;
  logic              w_load;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_asm_next;

  assign w_word_full = (r_recv_cnt == 3'd4);

  // The word is complete either because it already sits in r_asm, or because
  // its last byte lands this cycle. The second case lets the buffer load on
  // the same edge as the 4th byte, which gives the 5-cycle cadence.
  assign w_word_done = w_word_full || (r_outstanding && (r_recv_cnt == 3'd3));

  // Outputs are forced low while reset is held. This keeps the port quiet
  // during reset even though the counters already read as "ready to issue".
  assign w_req   = rst_in && (r_issue_cnt < 3'd4) && !w_word_full;
  assign w_addr  = r_fetch_pc + ADDR_W'(r_issue_cnt);
  assign w_issue = w_req && mem_grant_in;

  assign mem_req_out  = w_req;
  assign mem_addr_out = rst_in ? w_addr : '0;

  assign w_accept = r_valid && !stall_in;
  assign w_load   = w_word_done && (!r_valid || w_accept);

  // Returning byte merged into the slot at position recv_cnt.
  always_comb begin
    w_asm_next = r_asm;
    if (r_outstanding)
      w_asm_next[{r_recv_cnt[1:0], 3'b000} +: 8] = mem_byte_in;
  end

  // ---------------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_fetch_pc    <= RESET_PC;
      r_issue_cnt   <= '0;
      r_recv_cnt    <= '0;
      r_asm         <= '0;
      r_outstanding <= 1'b0;
      r_buf         <= '0;
      r_valid       <= 1'b0;
    end else if (jump_in) begin
      // Dropping the outstanding flag discards the byte for any request
      // granted up to and including this edge.
      r_fetch_pc    <= jump_addr_in;
      r_issue_cnt   <= '0;
      r_recv_cnt    <= '0;
      r_asm         <= '0;
      r_outstanding <= 1'b0;
      r_valid       <= 1'b0;
    end else begin
      r_outstanding <= w_issue;

      if (w_load) begin
        // When the word is complete, issue_cnt is 4. No request is in
        // flight, so both counters restart cleanly.
        r_buf.pc    <= r_fetch_pc;
        r_buf.inst  <= w_asm_next;
        r_valid     <= 1'b1;
        r_fetch_pc  <= r_fetch_pc + ADDR_W'(4);
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        r_asm       <= '0;
      end else begin
        if (w_accept)
          r_valid <= 1'b0;
        if (w_issue)
          r_issue_cnt <= r_issue_cnt + 3'd1;
        if (r_outstanding) begin
          r_asm      <= w_asm_next;
          r_recv_cnt <= r_recv_cnt + 3'd1;
        end
      end
    end
  end

  assign pc_out         = r_buf.pc;
  assign inst_out       = r_buf.inst;
  assign inst_valid_out = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- directed bench for if_fetch.
// Cycle n is the nth cycle after the last reset edge; the negedge in cycle n
// is where inputs change and outputs are sampled.
// Memory: mem[0..3] = 13 05 A0 00; every other byte = addr[7:0] ^ 8'hA5.
// -----------------------------------------------------------------------------
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_in, stall_in, jump_in, mem_grant_in;
  logic [31:0] jump_addr_in;
  logic [7:0]  mem_byte_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out, pc_out, inst_out;
  logic        inst_valid_out;

  int passed = 0;
  int total  = 0;

  if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst_in), .stall_in(stall_in), .jump_in(jump_in),
    .jump_addr_in(jump_addr_in), .mem_grant_in(mem_grant_in),
    .mem_byte_in(mem_byte_in), .mem_req_out(mem_req_out),
    .mem_addr_out(mem_addr_out), .pc_out(pc_out), .inst_out(inst_out),
    .inst_valid_out(inst_valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   memf = 8'h13;
      32'h1:   memf = 8'h05;
      32'h2:   memf = 8'hA0;
      32'h3:   memf = 8'h00;
      default: memf = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Byte returns one cycle after a grant. An ungranted cycle returns garbage,
  // so a byte that is wrongly captured corrupts the instruction.
  always @(posedge clk)
    mem_byte_in <= (mem_req_out && mem_grant_in) ? memf(mem_addr_out) : 8'hEE;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset for two edges, then release; returns in cycle 1.
  task automatic start();
    rst_in = 1'b0; stall_in = 1'b0; jump_in = 1'b0; mem_grant_in = 1'b1;
    jump_addr_in = 32'h0;
    cyc(2);
    rst_in = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; stall_in = 1'b0; jump_in = 1'b0; mem_grant_in = 1'b1;
    jump_addr_in = 32'h0;
    cyc(2);
    if (inst_valid_out !== 1'b0) $display("FAIL rst_valid got=%b exp=0", inst_valid_out); else passed++; total++;
    if (pc_out !== 32'h0) $display("FAIL rst_pc got=%h exp=0", pc_out); else passed++; total++;
    if (inst_out !== 32'h0) $display("FAIL rst_inst got=%h exp=0", inst_out); else passed++; total++;
    if (mem_req_out !== 1'b0) $display("FAIL rst_req got=%b exp=0", mem_req_out); else passed++; total++;
    if (mem_addr_out !== 32'h0) $display("FAIL rst_addr got=%h exp=0", mem_addr_out); else passed++; total++;
  endtask

  task automatic test_basic();
    start();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) cyc(1);
      if (mem_req_out !== 1'b1) $display("FAIL basic_req%0d got=%b exp=1", k, mem_req_out); else passed++; total++;
      if (mem_addr_out !== 32'(k)) $display("FAIL basic_addr%0d got=%h exp=%h", k, mem_addr_out, 32'(k)); else passed++; total++;
    end
    cyc(1); // cycle 5
    if (mem_req_out !== 1'b0) $display("FAIL basic_req_c5 got=%b exp=0", mem_req_out); else passed++; total++;
    if (inst_valid_out !== 1'b0) $display("FAIL basic_valid_c5 got=%b exp=0", inst_valid_out); else passed++; total++;
    cyc(1); // cycle 6
    if (inst_valid_out !== 1'b1) $display("FAIL basic_valid got=%b exp=1", inst_valid_out); else passed++; total++;
    if (inst_out !== 32'h00A00513) $display("FAIL basic_inst got=%h exp=00a00513", inst_out); else passed++; total++;
    if (pc_out !== 32'h0) $display("FAIL basic_pc got=%h exp=0", pc_out); else passed++; total++;
    if (mem_addr_out !== 32'h4) $display("FAIL basic_next_addr got=%h exp=4", mem_addr_out); else passed++; total++;
  endtask

  task automatic test_grant_gap();
    start();
    cyc(1); // cycle 2: grant withheld
    mem_grant_in = 1'b0;
    if (mem_addr_out !== 32'h1) $display("FAIL gap_addr_c2 got=%h exp=1", mem_addr_out); else passed++; total++;
    cyc(1); // cycle 3
    mem_grant_in = 1'b1;
    if (mem_req_out !== 1'b1) $display("FAIL gap_req_c3 got=%b exp=1", mem_req_out); else passed++; total++;
    if (mem_addr_out !== 32'h1) $display("FAIL gap_addr_held got=%h exp=1", mem_addr_out); else passed++; total++;
    cyc(1); // cycle 4
    if (mem_addr_out !== 32'h2) $display("FAIL gap_addr_c4 got=%h exp=2", mem_addr_out); else passed++; total++;
    cyc(2); // cycle 6
    if (inst_valid_out !== 1'b0) $display("FAIL gap_valid_c6 got=%b exp=0", inst_valid_out); else passed++; total++;
    cyc(1); // cycle 7
    if (inst_valid_out !== 1'b1) $display("FAIL gap_valid_c7 got=%b exp=1", inst_valid_out); else passed++; total++;
    if (inst_out !== 32'h00A00513) $display("FAIL gap_inst got=%h exp=00a00513", inst_out); else passed++; total++;
  endtask

  task automatic test_stall();
    start();
    cyc(5); // cycle 6: first word valid
    stall_in = 1'b1;
    cyc(9); // cycle 15: word at pc=4 complete and waiting
    if (inst_valid_out !== 1'b1) $display("FAIL stall_valid got=%b exp=1", inst_valid_out); else passed++; total++;
    if (pc_out !== 32'h0) $display("FAIL stall_pc got=%h exp=0", pc_out); else passed++; total++;
    if (inst_out !== 32'h00A00513) $display("FAIL stall_inst got=%h exp=00a00513", inst_out); else passed++; total++;
    if (mem_req_out !== 1'b0) $display("FAIL stall_req got=%b exp=0", mem_req_out); else passed++; total++;
    cyc(1); // cycle 16
    stall_in = 1'b0;
    cyc(1); // cycle 17
    if (inst_valid_out !== 1'b1) $display("FAIL unstall_valid got=%b exp=1", inst_valid_out); else passed++; total++;
    if (pc_out !== 32'h4) $display("FAIL unstall_pc got=%h exp=4", pc_out); else passed++; total++;
    if (inst_out !== 32'hA2A3A0A1) $display("FAIL unstall_inst got=%h exp=a2a3a0a1", inst_out); else passed++; total++;
    if (mem_addr_out !== 32'h8) $display("FAIL unstall_addr got=%h exp=8", mem_addr_out); else passed++; total++;
  endtask

  task automatic test_jump();
    start();
    cyc(5); // cycle 6
    stall_in = 1'b1; // keep the buffer full so the invalidate is visible
    cyc(3); // cycle 9: byte 2 of pc=4 in flight
    if (mem_addr_out !== 32'h7) $display("FAIL jump_pre_addr got=%h exp=7", mem_addr_out); else passed++; total++;
    jump_in = 1'b1; jump_addr_in = 32'h100;
    cyc(1); // cycle 10
    jump_in = 1'b0; stall_in = 1'b0;
    if (inst_valid_out !== 1'b0) $display("FAIL jump_valid got=%b exp=0", inst_valid_out); else passed++; total++;
    if (mem_req_out !== 1'b1) $display("FAIL jump_req got=%b exp=1", mem_req_out); else passed++; total++;
    if (mem_addr_out !== 32'h100) $display("FAIL jump_addr0 got=%h exp=100", mem_addr_out); else passed++; total++;
    cyc(3); // cycle 13
    if (mem_addr_out !== 32'h103) $display("FAIL jump_addr3 got=%h exp=103", mem_addr_out); else passed++; total++;
    cyc(2); // cycle 15
    if (inst_valid_out !== 1'b1) $display("FAIL jump_done_valid got=%b exp=1", inst_valid_out); else passed++; total++;
    if (pc_out !== 32'h100) $display("FAIL jump_pc got=%h exp=100", pc_out); else passed++; total++;
    if (inst_out !== 32'hA6A7A4A5) $display("FAIL jump_inst got=%h exp=a6a7a4a5", inst_out); else passed++; total++;
  endtask

  task automatic test_reset_mid();
    start();
    cyc(9); // cycle 10: byte 3 of pc=4 returning
    rst_in = 1'b0;
    cyc(1);
    if (inst_valid_out !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", inst_valid_out); else passed++; total++;
    if (inst_out !== 32'h0) $display("FAIL rmid_inst got=%h exp=0", inst_out); else passed++; total++;
    if (pc_out !== 32'h0) $display("FAIL rmid_pc got=%h exp=0", pc_out); else passed++; total++;
    if (mem_req_out !== 1'b0) $display("FAIL rmid_req got=%b exp=0", mem_req_out); else passed++; total++;
    rst_in = 1'b1; // cycle 1 of the restart
    #1;
    if (mem_addr_out !== 32'h0) $display("FAIL rmid_restart_addr got=%h exp=0", mem_addr_out); else passed++; total++;
    cyc(5); // cycle 6
    if (inst_valid_out !== 1'b1) $display("FAIL rmid_re_valid got=%b exp=1", inst_valid_out); else passed++; total++;
    if (inst_out !== 32'h00A00513) $display("FAIL rmid_re_inst got=%h exp=00a00513", inst_out); else passed++; total++;
  endtask

  task automatic test_wrap();
    start();
    jump_in = 1'b1; jump_addr_in = 32'hFFFF_FFFE;
    cyc(1); // cycle 2
    jump_in = 1'b0;
    if (mem_addr_out !== 32'hFFFF_FFFE) $display("FAIL wrap_addr0 got=%h exp=fffffffe", mem_addr_out); else passed++; total++;
    cyc(1);
    if (mem_addr_out !== 32'hFFFF_FFFF) $display("FAIL wrap_addr1 got=%h exp=ffffffff", mem_addr_out); else passed++; total++;
    cyc(1);
    if (mem_addr_out !== 32'h0) $display("FAIL wrap_addr2 got=%h exp=0", mem_addr_out); else passed++; total++;
    cyc(1);
    if (mem_addr_out !== 32'h1) $display("FAIL wrap_addr3 got=%h exp=1", mem_addr_out); else passed++; total++;
    cyc(2); // cycle 7
    if (inst_valid_out !== 1'b1) $display("FAIL wrap_valid got=%b exp=1", inst_valid_out); else passed++; total++;
    if (pc_out !== 32'hFFFF_FFFE) $display("FAIL wrap_pc got=%h exp=fffffffe", pc_out); else passed++; total++;
    if (inst_out !== 32'h05135A5B) $display("FAIL wrap_inst got=%h exp=05135a5b", inst_out); else passed++; total++;
    if (mem_addr_out !== 32'h2) $display("FAIL wrap_next_pc got=%h exp=2", mem_addr_out); else passed++; total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grant_gap();
    test_stall();
    test_jump();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
